// File: rtl/alu_pkg.sv
// alu_pkg: shared command/condition/operation encodings, flag indices and FSM states
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_TST = 4'b1000,
        CMD_CMP = 4'b1010,
        CMD_CMN = 4'b1011,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101
    } alu_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV} alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Codes come in true/inverted pairs: bits [3:1] pick the test, bit 0 inverts it.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        base = (cond[3:1] == 3'd0) ? z :
               (cond[3:1] == 3'd1) ? c :
               (cond[3:1] == 3'd2) ? n :
               (cond[3:1] == 3'd3) ? v :
               (cond[3:1] == 3'd4) ? (c & ~z) :
               (cond[3:1] == 3'd5) ? (n == v) :
               (cond[3:1] == 3'd6) ? (~z & (n == v)) : 1'b1;
        return (cond[3:1] == 3'd7) ? 1'b1 : base ^ cond[0];
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier, BITS multiplier bits retired per cycle
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int BITS  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int STEPS = WIDTH / BITS;
    localparam int CW = $clog2(STEPS);

    logic [WIDTH-1:0] acc, mcand, mplier, part;
    logic [CW-1:0]    cnt;
    logic             run;

    assign done = run & (cnt == CW'(STEPS - 1));
    assign product = acc;

    // Add in the shifted multiplicand for each set multiplier bit of this step.
    always_comb begin
        part = acc;
        for (int j = 0; j < BITS; j++)
            if (mplier[j]) part = part + (mcand << j);
    end

    // Step register: load on start, advance while running, stop on abort or last step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            acc <= '0;
            mcand <= a;
            mplier <= b;
            cnt <= '0;
            run <= 1'b1;
        end else if (abort) begin
            run <= 1'b0;
        end else if (run) begin
            acc <= part;
            mcand <= mcand << BITS;
            mplier <= mplier >> BITS;
            cnt <= cnt + 1'b1;
            run <= ~done;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decode, ARM condition check, ALU and NZCV flag file; multiply under ALU_MUL_EN
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MUL_BITS_CYC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic [3:0]       flags,
    output logic             undef,
    output logic             busy
);
    alu_op_e          alu_op;
    logic             set_f, is_cmp, und, sub, arith, carry, ovf, pass, accept, start_mul;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] b_eff, alu_res;
    logic [3:0]       new_flags;
    logic             unused_ok;

    assign unused_ok = ^{funct[5], MUL_BITS_CYC[0]};

`ifdef ALU_MUL_EN
    state_e           state;
    logic             is_mul, mul_s, mul_done;
    logic [WIDTH-1:0] product;
`endif

    // Map op/funct onto an ALU operation plus flag/write-back/undef qualifiers.
    always_comb begin
        alu_op = ALU_ADD;
        set_f = 1'b0;
        is_cmp = 1'b0;
        und = 1'b0;
`ifdef ALU_MUL_EN
        is_mul = 1'b0;
`endif
        case (op)
            2'b00: begin
                set_f = funct[0];
                case (alu_cmd_e'(funct[4:1]))
                    CMD_ADD: alu_op = ALU_ADD;
                    CMD_SUB: alu_op = ALU_SUB;
                    CMD_AND: alu_op = ALU_AND;
                    CMD_ORR: alu_op = ALU_ORR;
                    CMD_EOR: alu_op = ALU_EOR;
                    CMD_MOV: alu_op = ALU_MOV;
                    CMD_CMP: begin alu_op = ALU_SUB; is_cmp = 1'b1; end
                    CMD_CMN: begin alu_op = ALU_ADD; is_cmp = 1'b1; end
                    CMD_TST: begin alu_op = ALU_AND; is_cmp = 1'b1; end
                    default: und = 1'b1;
                endcase
            end
`ifdef ALU_MUL_EN
            2'b11: begin is_mul = 1'b1; set_f = funct[0]; end
`else
            2'b11: und = 1'b1;
`endif
            default: ;
        endcase
    end

    assign sub       = (alu_op == ALU_SUB);
    assign arith     = (alu_op == ALU_ADD) | sub;
    assign b_eff     = sub ? ~src_b : src_b;
    assign sum_full  = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign carry     = sum_full[WIDTH];
    assign ovf       = (src_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum_full[WIDTH-1] != src_a[WIDTH-1]);
    assign alu_res   = arith               ? sum_full[WIDTH-1:0] :
                       (alu_op == ALU_AND) ? (src_a & src_b) :
                       (alu_op == ALU_ORR) ? (src_a | src_b) :
                       (alu_op == ALU_EOR) ? (src_a ^ src_b) : src_b;
    assign new_flags = {alu_res[WIDTH-1], alu_res == '0,
                        arith ? carry : flags[FLAG_C], arith ? ovf : flags[FLAG_V]};
    assign pass      = cond_pass(cond, flags);
    assign accept    = in_valid & in_ready;

`ifdef ALU_MUL_EN
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign start_mul = accept & is_mul & pass;

    mul_iter #(.WIDTH(WIDTH), .BITS(MUL_BITS_CYC)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_mul),
        .abort   (flush & (state == MUL)),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (product)
    );

    // Multiply sequencing: flush abandons the product, DONE lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mul_s <= 1'b0;
        end else if (state == IDLE) begin
            state <= start_mul ? MUL : IDLE;
            mul_s <= start_mul ? set_f : mul_s;
        end else if (state == MUL) begin
            state <= flush ? IDLE : mul_done ? DONE : MUL;
        end else begin
            state <= IDLE;
        end
    end
`else
    assign in_ready  = 1'b1;
    assign busy      = 1'b0;
    assign start_mul = 1'b0;
`endif

    // Registered outputs and flag file; cond/undef gate write-back and flag updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result <= '0;
            result_we <= 1'b0;
            flags <= '0;
            undef <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            result_we <= 1'b0;
            undef <= 1'b0;
            if (accept & ~start_mul) begin
                out_valid <= 1'b1;
                result <= alu_res;
                result_we <= pass & ~is_cmp & ~und;
                undef <= und;
                if (pass & ~und & (set_f | is_cmp)) flags <= new_flags;
            end
`ifdef ALU_MUL_EN
            if (state == DONE) begin
                out_valid <= 1'b1;
                result <= product;
                result_we <= 1'b1;
                if (mul_s) flags[FLAG_N:FLAG_Z] <= {product[WIDTH-1], product == '0};
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed results for alu_exec_unit
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, flush;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cond;
    logic [31:0] src_a, src_b;
    logic        in_ready, out_valid, result_we, undef, busy;
    logic [31:0] result;
    logic [3:0]  flags;
    int          checks = 0;
    int          errors = 0;

    alu_exec_unit #(.WIDTH(32), .MUL_BITS_CYC(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct     (funct),
        .cond      (cond),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .result_we (result_we),
        .flags     (flags),
        .undef     (undef),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] fn(input logic [3:0] cmd, input logic s);
        return {1'b0, cmd, s};
    endfunction

    task automatic drive(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; funct = f; cond = c; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        op = 2'b00; funct = '0; cond = 4'b1110; src_a = '0; src_b = '0;
        #22 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);

        drive(2'b00, fn(4'b0100, 1), 4'b1110, 32'd5, 32'hFFFF_FFFB);
        check("adds_valid", out_valid, 1);
        check("adds_res", result, 0);
        check("adds_we", result_we, 1);
        check("adds_flags", flags, 4'b0110);

        drive(2'b00, fn(4'b1010, 0), 4'b1110, 32'd3, 32'd7);
        check("cmp_we", result_we, 0);
        check("cmp_flags", flags, 4'b1000);

        drive(2'b00, fn(4'b0100, 1), 4'b0000, 32'd1, 32'd1);
        check("eq_fail_valid", out_valid, 1);
        check("eq_fail_we", result_we, 0);
        check("eq_fail_flags", flags, 4'b1000);

        drive(2'b00, fn(4'b0010, 1), 4'b1110, 32'h8000_0000, 32'd1);
        check("subs_res", result, 32'h7FFF_FFFF);
        check("subs_flags", flags, 4'b0011);

        drive(2'b00, fn(4'b0000, 1), 4'b1110, 32'hF0, 32'h0F);
        check("ands_res", result, 0);
        check("ands_flags", flags, 4'b0111);

        drive(2'b00, fn(4'b1100, 1), 4'b1110, 32'hF0, 32'h0F);
        check("orrs_res", result, 32'hFF);
        check("orrs_flags", flags, 4'b0011);

        drive(2'b00, fn(4'b0001, 0), 4'b1110, 32'hFF, 32'h0F);
        check("eor_res", result, 32'hF0);
        check("eor_flags", flags, 4'b0011);

        drive(2'b00, fn(4'b1011, 0), 4'b1110, 32'h7FFF_FFFF, 32'd1);
        check("cmn_res", result, 32'h8000_0000);
        check("cmn_we", result_we, 0);
        check("cmn_flags", flags, 4'b1001);

        drive(2'b00, fn(4'b1101, 0), 4'b1010, 32'hDEAD, 32'h1234);
        check("mov_ge_res", result, 32'h1234);
        check("mov_ge_we", result_we, 1);

        drive(2'b00, fn(4'b1101, 0), 4'b1011, 32'hDEAD, 32'h1234);
        check("mov_lt_we", result_we, 0);

        drive(2'b00, fn(4'b1101, 0), 4'b1111, 32'd0, 32'h55);
        check("mov_nv_we", result_we, 1);

        drive(2'b01, fn(4'b0000, 1), 4'b1110, 32'h10, 32'h20);
        check("mem_res", result, 32'h30);
        check("mem_we", result_we, 1);
        check("mem_flags", flags, 4'b1001);

        drive(2'b00, fn(4'b0011, 1), 4'b1110, 32'd1, 32'd2);
        check("undef_pulse", undef, 1);
        check("undef_valid", out_valid, 1);
        check("undef_we", result_we, 0);
        check("undef_flags", flags, 4'b1001);
        @(posedge clk); #1;
        check("undef_clear", undef, 0);
        check("idle_valid", out_valid, 0);

        drive(2'b00, fn(4'b1000, 0), 4'b1110, 32'd1, 32'd1);
        check("tst_we", result_we, 0);
        check("tst_flags", flags, 4'b0001);

        @(negedge clk);
        op = 2'b00; funct = fn(4'b0100, 0); cond = 4'b1110; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_first", result, 32'd3);
        funct = fn(4'b0010, 0); src_a = 32'd10; src_b = 32'd3;
        @(posedge clk); #1;
        check("b2b_second", result, 32'd7);
        check("b2b_valid", out_valid, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drop", out_valid, 0);

`ifdef ALU_MUL_EN
        @(negedge clk);
        op = 2'b11; funct = fn(4'b0000, 1); cond = 4'b1110; src_a = 32'h0001_0003; src_b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 2'b00; funct = fn(4'b0100, 1);
        check("mul_busy", busy, 1);
        for (int j = 1; j <= 32; j++) begin
            @(posedge clk); #1;
            check("mul_in_ready", in_ready, 0);
            check("mul_early_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        check("mul_valid", out_valid, 1);
        check("mul_res", result, 32'h0005_000F);
        check("mul_we", result_we, 1);
        check("mul_flags", flags, 4'b0001);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        check("mul_held_not_taken", out_valid, 0);

        drive(2'b11, fn(4'b0000, 0), 4'b1110, 32'd7, 32'd9);
        for (int j = 1; j <= 10; j++) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        begin
            int seen = 0;
            for (int j = 0; j < 30; j++) begin
                @(posedge clk); #1;
                seen += out_valid;
            end
            check("flush_no_valid", seen, 0);
        end
        check("flush_flags", flags, 4'b0001);

        drive(2'b11, fn(4'b0000, 1), 4'b1110, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_flags", flags, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_we", result_we, 0);
`else
        drive(2'b11, fn(4'b0000, 1), 4'b1110, 32'h0001_0003, 32'd5);
        check("op11_undef", undef, 1);
        check("op11_valid", out_valid, 1);
        check("op11_we", result_we, 0);
        check("op11_flags", flags, 4'b0001);
        check("op11_busy", busy, 0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_undef", undef, 0);
        check("rst_mid_flags", flags, 0);
        check("rst_mid_result", result, 0);
`endif
        #20 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
